mprc_s2_hit_pipe: RTL and testbench
===================================

MPRC_S2_HIT_PIPE -- requirements
Module: mprc_s2_hit_pipe

Interface
REQ-001 The block SHALL have parameter NWAYS, default 4, giving the associativity; legal values are 2, 4 and 8.
REQ-002 The block SHALL have parameter TAG_W, default 20, giving the tag width.
REQ-003 The block SHALL have parameter NSETS, default 64, a power of 2; IDX_W = log2(NSETS).
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 s1_valid  input  1  an s1 request is present.
REQ-007 s1_ready  output  1  s1 can advance into s2 this cycle.
REQ-008 s1_cmd  input  5  memory command, using the `M_*` encodings.
REQ-009 s1_idx  input  IDX_W  set index.
REQ-010 s1_tag  input  TAG_W  request tag.
REQ-011 meta_resp_coh  input  2*NWAYS  coherence state per way; way w occupies bits [2w+1:2w].
REQ-012 meta_resp_tag  input  TAG_W*NWAYS  tag per way; way w occupies slice w.
REQ-013 s2_ready  input  1  downstream accepts s2 this cycle.
REQ-014 s2_valid  output  1  s2 holds a request.
REQ-015 s2_hit, s2_tag_match, s2_multi_hit  outputs  1 each  hit, tag match and multi-match error flags.
REQ-016 s2_hit_way, s2_repl_way_en  outputs  NWAYS each  one-hot hit way and one-hot victim way.
REQ-017 s2_hit_state, s2_repl_coh  outputs  2 each  coherence state of the hit way and of the victim way.
REQ-018 s2_repl_tag  output  TAG_W  tag of the victim way.
REQ-019 s2_cmd, s2_idx  outputs  5, IDX_W  registered copies of the request command and index.

Function
REQ-020 Way w SHALL match when its coh is not `clientInvalid and its tag equals s1_tag; the match vector is computed in s1 and registered into s2.
REQ-021 s2_fire is s2_valid & s2_ready; s1_ready SHALL equal !s2_valid | s2_ready.
REQ-022 When s1_valid & s1_ready, all s2 registers SHALL load from s1 and s2_valid SHALL become 1.
REQ-023 When !s1_valid & s2_fire, s2_valid SHALL become 0.
REQ-024 When s2_valid & !s2_ready, every s2 output SHALL hold its value unchanged.
REQ-025 s2_tag_match SHALL be the OR of the match vector.
REQ-026 s2_hit_way SHALL select the lowest-index matching way; it is all zeros when no way matches.
REQ-027 s2_multi_hit SHALL be 1 when more than one way matches.
REQ-028 s2_hit_state SHALL be the coh of s2_hit_way, or 0 when there is no match.
REQ-029 Write-intent commands are M_XWR, M_XSC, any cmd with bit 3 set, M_XA_SWAP, M_PFW and M_XLR.
REQ-030 Write commands are M_XWR, M_XSC, any cmd with bit 3 set, and M_XA_SWAP.
REQ-031 s2_hit SHALL equal tag_match & !multi_hit & (writeintent ? state in {ExclusiveClean, ExclusiveDirty} : state != Invalid) & (write ? state == ExclusiveDirty : 1).
REQ-032 Each set SHALL hold tree-PLRU state of NWAYS-1 bits; node bit 0 points the victim toward the lower-index subtree.
REQ-033 Victim selection in s1 SHALL pick the lowest-index way whose coh is `clientInvalid; if no way is invalid, it SHALL take the PLRU victim of s1_idx.
REQ-034 The s1 PLRU read SHALL be write-first: a same-cycle s2 PLRU update to the same index is forwarded to the read.
REQ-035 On s2_fire with s2_tag_match, the PLRU of s2_idx SHALL be touched with s2_hit_way; every node on that way's path is set to point away from it.
REQ-036 On s2_fire with no tag match, the PLRU of s2_idx SHALL be touched with s2_repl_way_en.
REQ-037 Without s2_fire, PLRU state SHALL NOT change.
REQ-038 s2_repl_coh and s2_repl_tag SHALL be the meta of the victim way, registered in s1.
REQ-039 Latency from s1 accept to valid s2 outputs SHALL be exactly 1 cycle.
REQ-040 A back-to-back stream with s2_ready held at 1 SHALL sustain 1 request per cycle.

Reset
REQ-041 While reset is 1, s2_valid SHALL be 0 and all PLRU bits SHALL be 0, taking effect at the next clock edge, including a reset asserted mid-stall.
REQ-042 Reset SHALL force the s2 data outputs (s2_hit_way, s2_repl_way_en, s2_hit_state, s2_repl_coh, s2_repl_tag, s2_cmd, s2_idx) to 0.
REQ-043 Reset SHALL force s2_hit, s2_tag_match and s2_multi_hit to 0.
REQ-044 s1_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-045 NWAYS=4, way 2 holds tag 0x12345 in ExclusiveDirty, cmd M_XWR -> s2_hit=1, s2_hit_way=0100, s2_hit_state=3, one cycle after accept.
REQ-046 Way 1 ExclusiveClean matches, cmd M_XWR -> s2_tag_match=1, s2_hit=0; the same way with cmd M_XRD -> s2_hit=1.
REQ-047 All ways valid, no match, after reset -> s2_repl_way_en=0001; after that miss fires, a miss to the same set -> 0100; a miss to a different set -> 0001.
REQ-048 Ways 1 and 3 both match -> s2_multi_hit=1, s2_hit=0, s2_hit_way=0010.
REQ-049 Hold s2_ready=0 for 3 cycles with s1_valid=1 -> s1_ready=0 and s2 outputs and PLRU stable; release -> the held request fires and the next request loads.
REQ-050 Assert reset during a stall -> next cycle s2_valid=0, then a miss -> s2_repl_way_en=0001; also run NWAYS=2 and NWAYS=8 builds, checking victim order 0,1 and 0,4,2,6.

Source files
------------

// File: rtl/mprc_s2_hit_pipe.sv
// Stage-2 tag-compare pipeline register for a set-associative cache: registers
// per-way hit/match results, hit permission and a victim choice (invalid-first, then tree PLRU).
module mprc_s2_hit_pipe #(
    parameter int NWAYS = 4,
    parameter int TAG_W = 20,
    parameter int NSETS = 64,
    localparam int IDX_W = $clog2(NSETS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s1_valid,
    output logic                     s1_ready,
    input  logic [4:0]               s1_cmd,
    input  logic [IDX_W-1:0]         s1_idx,
    input  logic [TAG_W-1:0]         s1_tag,
    input  logic [2*NWAYS-1:0]       meta_resp_coh,
    input  logic [TAG_W*NWAYS-1:0]   meta_resp_tag,
    input  logic                     s2_ready,
    output logic                     s2_valid,
    output logic                     s2_hit,
    output logic                     s2_tag_match,
    output logic                     s2_multi_hit,
    output logic [NWAYS-1:0]         s2_hit_way,
    output logic [NWAYS-1:0]         s2_repl_way_en,
    output logic [1:0]               s2_hit_state,
    output logic [1:0]               s2_repl_coh,
    output logic [TAG_W-1:0]         s2_repl_tag,
    output logic [4:0]               s2_cmd,
    output logic [IDX_W-1:0]         s2_idx
);

    localparam int LVLS = $clog2(NWAYS);

    localparam logic [4:0] M_XWR     = 5'b00001;
    localparam logic [4:0] M_PFW     = 5'b00011;
    localparam logic [4:0] M_XA_SWAP = 5'b00100;
    localparam logic [4:0] M_XLR     = 5'b00110;
    localparam logic [4:0] M_XSC     = 5'b00111;

    localparam logic [1:0] COH_INVALID    = 2'd0;
    localparam logic [1:0] COH_EXCL_CLEAN = 2'd2;
    localparam logic [1:0] COH_EXCL_DIRTY = 2'd3;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 0 bit steers toward the lower half.
    function automatic logic [NWAYS-2:0] plru_touch(input logic [NWAYS-2:0] st,
                                                    input logic [LVLS-1:0] way);
        logic [LVLS-1:0] node;
        logic [LVLS-1:0] w;
        node = '0;
        w    = way;
        for (int unsigned l = 0; l < LVLS; l++) begin
            st[node] = ~w[LVLS-1];
            node     = (node << 1) + LVLS'(1) + LVLS'(w[LVLS-1]);
            w        = w << 1;
        end
        return st;
    endfunction

    function automatic logic [LVLS-1:0] plru_victim(input logic [NWAYS-2:0] st);
        logic [LVLS-1:0] node;
        logic [LVLS-1:0] v;
        logic            b;
        node = '0;
        v    = '0;
        for (int unsigned l = 0; l < LVLS; l++) begin
            b    = st[node];
            v    = (v << 1) | LVLS'(b);
            node = (node << 1) + LVLS'(1) + LVLS'(b);
        end
        return v;
    endfunction

    function automatic logic [LVLS-1:0] oh_to_idx(input logic [NWAYS-1:0] oh);
        logic [LVLS-1:0] idx;
        idx = '0;
        for (int unsigned w = 0; w < NWAYS; w++)
            if (oh[w]) idx = idx | LVLS'(w);
        return idx;
    endfunction

    logic [NWAYS-2:0]   plru [NSETS];
    logic [NWAYS-2:0]   plru_next;
    logic [NWAYS-2:0]   s1_plru;
    logic [NWAYS-1:0]   upd_way;
    logic               s2_fire;

    logic [NWAYS-1:0]   s1_match;
    logic [NWAYS-1:0]   s1_hit_way;
    logic [NWAYS-1:0]   s1_repl_way_en;
    logic [1:0]         s1_hit_state;
    logic [1:0]         s1_repl_coh;
    logic [TAG_W-1:0]   s1_repl_tag;
    logic               s1_tag_match;
    logic               s1_multi_hit;
    logic               s1_hit;
    logic               s1_write;
    logic               s1_write_intent;
    logic               hit_found;
    logic               inv_found;
    logic [1:0]         way_coh;
    logic [TAG_W-1:0]   way_tag;

    assign s2_fire  = s2_valid & s2_ready;
    assign s1_ready = !s2_valid | s2_ready;

    // A same-cycle s2 touch of the set being read in s1 is forwarded so back-to-back misses pick fresh victims.
    assign upd_way   = s2_tag_match ? s2_hit_way : s2_repl_way_en;
    assign plru_next = plru_touch(plru[s2_idx], oh_to_idx(upd_way));
    assign s1_plru   = (s2_fire && s2_idx == s1_idx) ? plru_next : plru[s1_idx];

    always_comb begin
        s1_match       = '0;
        s1_hit_way     = '0;
        s1_repl_way_en = '0;
        s1_hit_state   = '0;
        s1_repl_coh    = '0;
        s1_repl_tag    = '0;
        hit_found      = 1'b0;
        inv_found      = 1'b0;
        way_coh        = '0;
        way_tag        = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            way_coh = meta_resp_coh[2*w +: 2];
            way_tag = meta_resp_tag[TAG_W*w +: TAG_W];
            if (way_coh != COH_INVALID && way_tag == s1_tag) begin
                s1_match[w] = 1'b1;
                if (!hit_found) begin
                    hit_found     = 1'b1;
                    s1_hit_way[w] = 1'b1;
                    s1_hit_state  = way_coh;
                end
            end
            if (way_coh == COH_INVALID && !inv_found) begin
                inv_found         = 1'b1;
                s1_repl_way_en[w] = 1'b1;
            end
        end
        if (!inv_found)
            s1_repl_way_en = NWAYS'(1) << plru_victim(s1_plru);
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (s1_repl_way_en[w]) begin
                s1_repl_coh = meta_resp_coh[2*w +: 2];
                s1_repl_tag = meta_resp_tag[TAG_W*w +: TAG_W];
            end
        end
        s1_tag_match    = |s1_match;
        s1_multi_hit    = |(s1_match & (s1_match - NWAYS'(1)));
        s1_write        = s1_cmd == M_XWR || s1_cmd == M_XSC || s1_cmd[3] || s1_cmd == M_XA_SWAP;
        s1_write_intent = s1_write || s1_cmd == M_PFW || s1_cmd == M_XLR;
        s1_hit          = s1_tag_match && !s1_multi_hit
                          && (s1_write_intent ? (s1_hit_state inside {COH_EXCL_CLEAN, COH_EXCL_DIRTY})
                                              : (s1_hit_state != COH_INVALID))
                          && (!s1_write || s1_hit_state == COH_EXCL_DIRTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < NSETS; s++)
                plru[s] <= '0;
        end else if (s2_fire) begin
            plru[s2_idx] <= plru_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid       <= 1'b0;
            s2_hit         <= 1'b0;
            s2_tag_match   <= 1'b0;
            s2_multi_hit   <= 1'b0;
            s2_hit_way     <= '0;
            s2_repl_way_en <= '0;
            s2_hit_state   <= '0;
            s2_repl_coh    <= '0;
            s2_repl_tag    <= '0;
            s2_cmd         <= '0;
            s2_idx         <= '0;
        end else if (s1_valid && s1_ready) begin
            s2_valid       <= 1'b1;
            s2_hit         <= s1_hit;
            s2_tag_match   <= s1_tag_match;
            s2_multi_hit   <= s1_multi_hit;
            s2_hit_way     <= s1_hit_way;
            s2_repl_way_en <= s1_repl_way_en;
            s2_hit_state   <= s1_hit_state;
            s2_repl_coh    <= s1_repl_coh;
            s2_repl_tag    <= s1_repl_tag;
            s2_cmd         <= s1_cmd;
            s2_idx         <= s1_idx;
        end else if (s2_fire) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mprc_s2_hit_pipe.sv
// Directed bench for mprc_s2_hit_pipe: a 4-way instance for hit/miss/stall/reset
// behaviour plus 2-way and 8-way instances sharing the request for victim order.
module tb_mprc_s2_hit_pipe;

    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [4:0] M_XWR = 5'b00001;
    localparam logic [4:0] M_PFW = 5'b00011;

    logic         clk = 1'b0;
    logic         reset;
    logic         s1_valid;
    logic [4:0]   s1_cmd;
    logic [5:0]   s1_idx;
    logic [19:0]  s1_tag;
    logic         s2_ready;

    logic [7:0]   m4_coh;
    logic [79:0]  m4_tag;
    logic [3:0]   m2_coh = {2'd1, 2'd1};
    logic [39:0]  m2_tag = {20'hFFFFF, 20'hFFFFE};
    logic [15:0]  m8_coh = {8{2'b01}};
    logic [159:0] m8_tag = {8{20'hFFFFF}};

    logic        s1_ready4, s2_valid4, s2_hit4, s2_tag_match4, s2_multi_hit4;
    logic [3:0]  s2_hit_way4, s2_repl_way_en4;
    logic [1:0]  s2_hit_state4, s2_repl_coh4;
    logic [19:0] s2_repl_tag4;
    logic [4:0]  s2_cmd4;
    logic [5:0]  s2_idx4;

    logic        s1_ready2, s2_valid2, s2_hit2, s2_tag_match2, s2_multi_hit2;
    logic [1:0]  s2_hit_way2, s2_repl_way_en2;
    logic [1:0]  s2_hit_state2, s2_repl_coh2;
    logic [19:0] s2_repl_tag2;
    logic [4:0]  s2_cmd2;
    logic [5:0]  s2_idx2;

    logic        s1_ready8, s2_valid8, s2_hit8, s2_tag_match8, s2_multi_hit8;
    logic [7:0]  s2_hit_way8, s2_repl_way_en8;
    logic [1:0]  s2_hit_state8, s2_repl_coh8;
    logic [19:0] s2_repl_tag8;
    logic [4:0]  s2_cmd8;
    logic [5:0]  s2_idx8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mprc_s2_hit_pipe #(.NWAYS(4), .TAG_W(20), .NSETS(64)) dut4 (
        .clk(clk), .reset(reset), .s1_valid(s1_valid), .s1_ready(s1_ready4),
        .s1_cmd(s1_cmd), .s1_idx(s1_idx), .s1_tag(s1_tag),
        .meta_resp_coh(m4_coh), .meta_resp_tag(m4_tag), .s2_ready(s2_ready),
        .s2_valid(s2_valid4), .s2_hit(s2_hit4), .s2_tag_match(s2_tag_match4),
        .s2_multi_hit(s2_multi_hit4), .s2_hit_way(s2_hit_way4), .s2_repl_way_en(s2_repl_way_en4),
        .s2_hit_state(s2_hit_state4), .s2_repl_coh(s2_repl_coh4), .s2_repl_tag(s2_repl_tag4),
        .s2_cmd(s2_cmd4), .s2_idx(s2_idx4)
    );

    mprc_s2_hit_pipe #(.NWAYS(2), .TAG_W(20), .NSETS(64)) dut2 (
        .clk(clk), .reset(reset), .s1_valid(s1_valid), .s1_ready(s1_ready2),
        .s1_cmd(s1_cmd), .s1_idx(s1_idx), .s1_tag(s1_tag),
        .meta_resp_coh(m2_coh), .meta_resp_tag(m2_tag), .s2_ready(s2_ready),
        .s2_valid(s2_valid2), .s2_hit(s2_hit2), .s2_tag_match(s2_tag_match2),
        .s2_multi_hit(s2_multi_hit2), .s2_hit_way(s2_hit_way2), .s2_repl_way_en(s2_repl_way_en2),
        .s2_hit_state(s2_hit_state2), .s2_repl_coh(s2_repl_coh2), .s2_repl_tag(s2_repl_tag2),
        .s2_cmd(s2_cmd2), .s2_idx(s2_idx2)
    );

    mprc_s2_hit_pipe #(.NWAYS(8), .TAG_W(20), .NSETS(64)) dut8 (
        .clk(clk), .reset(reset), .s1_valid(s1_valid), .s1_ready(s1_ready8),
        .s1_cmd(s1_cmd), .s1_idx(s1_idx), .s1_tag(s1_tag),
        .meta_resp_coh(m8_coh), .meta_resp_tag(m8_tag), .s2_ready(s2_ready),
        .s2_valid(s2_valid8), .s2_hit(s2_hit8), .s2_tag_match(s2_tag_match8),
        .s2_multi_hit(s2_multi_hit8), .s2_hit_way(s2_hit_way8), .s2_repl_way_en(s2_repl_way_en8),
        .s2_hit_state(s2_hit_state8), .s2_repl_coh(s2_repl_coh8), .s2_repl_tag(s2_repl_tag8),
        .s2_cmd(s2_cmd8), .s2_idx(s2_idx8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [4:0] cmd, input logic [5:0] idx, input logic [19:0] tag);
        s1_valid = v;
        s1_cmd   = cmd;
        s1_idx   = idx;
        s1_tag   = tag;
    endtask

    task automatic meta4(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2, input logic [1:0] c3,
                         input logic [19:0] t0, input logic [19:0] t1, input logic [19:0] t2, input logic [19:0] t3);
        m4_coh = {c3, c2, c1, c0};
        m4_tag = {t3, t2, t1, t0};
    endtask

    initial begin
        reset    = 1'b1;
        s2_ready = 1'b1;
        req(1'b0, M_XRD, 6'd0, 20'h0);
        meta4(2'd0, 2'd0, 2'd0, 2'd0, 20'h0, 20'h0, 20'h0, 20'h0);
        step();
        step();
        chk("rst_valid", 32'(s2_valid4), 32'h0);
        chk("rst_hit_way", 32'(s2_hit_way4), 32'h0);
        chk("rst_repl_way", 32'(s2_repl_way_en4), 32'h0);
        chk("rst_cmd", 32'(s2_cmd4), 32'h0);
        chk("rst_hit", 32'(s2_hit4), 32'h0);
        reset = 1'b0;
        step();
        chk("s1_ready_after_rst", 32'(s1_ready4), 32'h1);

        // Write hit on ExclusiveDirty way 2
        meta4(2'd1, 2'd1, 2'd3, 2'd1, 20'h11111, 20'h22222, 20'h12345, 20'h44444);
        req(1'b1, M_XWR, 6'd5, 20'h12345);
        step();
        chk("wr_hit_valid", 32'(s2_valid4), 32'h1);
        chk("wr_hit", 32'(s2_hit4), 32'h1);
        chk("wr_hit_way", 32'(s2_hit_way4), 32'b0100);
        chk("wr_hit_state", 32'(s2_hit_state4), 32'h3);
        chk("wr_hit_tm", 32'(s2_tag_match4), 32'h1);
        chk("wr_hit_cmd", 32'(s2_cmd4), 32'h1);
        chk("wr_hit_idx", 32'(s2_idx4), 32'h5);

        // ExclusiveClean way 1: write misses permission, read hits
        meta4(2'd1, 2'd2, 2'd1, 2'd1, 20'h11111, 20'hABCDE, 20'h33333, 20'h44444);
        req(1'b1, M_XWR, 6'd6, 20'hABCDE);
        step();
        chk("ec_wr_tm", 32'(s2_tag_match4), 32'h1);
        chk("ec_wr_hit", 32'(s2_hit4), 32'h0);
        chk("ec_wr_way", 32'(s2_hit_way4), 32'b0010);
        chk("ec_wr_state", 32'(s2_hit_state4), 32'h2);
        req(1'b1, M_XRD, 6'd6, 20'hABCDE);
        step();
        chk("ec_rd_hit", 32'(s2_hit4), 32'h1);

        // All-valid misses: PLRU victim order with same-cycle forwarding
        meta4(2'd1, 2'd2, 2'd3, 2'd1, 20'h00A00, 20'h00A01, 20'h00A02, 20'h00A03);
        req(1'b1, M_XRD, 6'd0, 20'h77777);
        step();
        chk("miss1_way", 32'(s2_repl_way_en4), 32'b0001);
        chk("miss1_coh", 32'(s2_repl_coh4), 32'h1);
        chk("miss1_tag", 32'(s2_repl_tag4), 32'h00A00);
        chk("miss1_tm", 32'(s2_tag_match4), 32'h0);
        chk("miss1_hit", 32'(s2_hit4), 32'h0);
        req(1'b1, M_XRD, 6'd0, 20'h77778);
        step();
        chk("miss2_way", 32'(s2_repl_way_en4), 32'b0100);
        chk("miss2_coh", 32'(s2_repl_coh4), 32'h3);
        chk("miss2_tag", 32'(s2_repl_tag4), 32'h00A02);
        req(1'b1, M_XRD, 6'd1, 20'h77779);
        step();
        chk("miss_other_set", 32'(s2_repl_way_en4), 32'b0001);

        // Invalid way preferred over PLRU
        meta4(2'd1, 2'd1, 2'd0, 2'd1, 20'h00A00, 20'h00A01, 20'h00A02, 20'h00A03);
        req(1'b1, M_XRD, 6'd1, 20'h7777A);
        step();
        chk("inv_victim", 32'(s2_repl_way_en4), 32'b0100);
        chk("inv_victim_coh", 32'(s2_repl_coh4), 32'h0);

        // Multi-hit on ways 1 and 3
        meta4(2'd1, 2'd2, 2'd1, 2'd3, 20'h00001, 20'h55555, 20'h00002, 20'h55555);
        req(1'b1, M_XRD, 6'd7, 20'h55555);
        step();
        chk("multi_flag", 32'(s2_multi_hit4), 32'h1);
        chk("multi_hit", 32'(s2_hit4), 32'h0);
        chk("multi_way", 32'(s2_hit_way4), 32'b0010);
        chk("multi_tm", 32'(s2_tag_match4), 32'h1);
        chk("multi_state", 32'(s2_hit_state4), 32'h2);

        // Stall for 3 cycles, then release
        meta4(2'd1, 2'd1, 2'd1, 2'd1, 20'h00A00, 20'h00A01, 20'h00A02, 20'h00A03);
        req(1'b1, M_XWR, 6'd2, 20'h66666);
        step();
        chk("stall_a_way", 32'(s2_repl_way_en4), 32'b0001);
        s2_ready = 1'b0;
        req(1'b1, M_PFW, 6'd2, 20'h66667);
        #1;
        chk("stall_s1_ready", 32'(s1_ready4), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(s2_valid4), 32'h1);
            chk("stall_cmd", 32'(s2_cmd4), 32'h1);
            chk("stall_idx", 32'(s2_idx4), 32'h2);
            chk("stall_repl", 32'(s2_repl_way_en4), 32'b0001);
            chk("stall_s1_ready", 32'(s1_ready4), 32'h0);
        end
        s2_ready = 1'b1;
        #1;
        chk("release_s1_ready", 32'(s1_ready4), 32'h1);
        step();
        chk("release_b_cmd", 32'(s2_cmd4), 32'h3);
        chk("release_b_valid", 32'(s2_valid4), 32'h1);
        chk("release_b_repl", 32'(s2_repl_way_en4), 32'b0100);
        req(1'b0, M_XRD, 6'd0, 20'h0);
        step();
        chk("drain_valid", 32'(s2_valid4), 32'h0);

        // Reset during a stall clears s2 and PLRU (set 0 would otherwise pick way 1)
        req(1'b1, M_XRD, 6'd3, 20'h70000);
        step();
        s2_ready = 1'b0;
        req(1'b1, M_XRD, 6'd3, 20'h70001);
        step();
        reset = 1'b1;
        step();
        chk("midrst_valid", 32'(s2_valid4), 32'h0);
        chk("midrst_repl", 32'(s2_repl_way_en4), 32'h0);
        chk("midrst_idx", 32'(s2_idx4), 32'h0);
        chk("midrst_repl_tag", 32'(s2_repl_tag4), 32'h0);
        chk("midrst_s1_ready", 32'(s1_ready4), 32'h1);
        reset    = 1'b0;
        s2_ready = 1'b1;
        req(1'b1, M_XRD, 6'd0, 20'h77777);
        step();
        chk("postrst_repl", 32'(s2_repl_way_en4), 32'b0001);

        // Victim order for 2-way and 8-way builds on a fresh set
        req(1'b1, M_XRD, 6'd10, 20'h10000);
        step();
        chk("w8_v0", 32'(s2_repl_way_en8), 32'h01);
        chk("w2_v0", 32'(s2_repl_way_en2), 32'h1);
        req(1'b1, M_XRD, 6'd10, 20'h10001);
        step();
        chk("w8_v1", 32'(s2_repl_way_en8), 32'h10);
        chk("w2_v1", 32'(s2_repl_way_en2), 32'h2);
        req(1'b1, M_XRD, 6'd10, 20'h10002);
        step();
        chk("w8_v2", 32'(s2_repl_way_en8), 32'h04);
        chk("w2_v2", 32'(s2_repl_way_en2), 32'h1);
        req(1'b1, M_XRD, 6'd10, 20'h10003);
        step();
        chk("w8_v3", 32'(s2_repl_way_en8), 32'h40);
        chk("w2_v3", 32'(s2_repl_way_en2), 32'h2);
        req(1'b0, M_XRD, 6'd0, 20'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
